// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: start/busy/done request bundle for the RV32M muldiv unit.
// The master issues operations and the slave returns results.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [2:0]       MulDivOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  modport master (
    output Start, Flush, MulDivOp, Operand1, Operand2,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Flush, MulDivOp, Operand1, Operand2,
    output Busy, Done, Result
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide, one bit per cycle.
// ALU_MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic         CPU_CLK,
  input logic         CPU_RSTN,
  alu_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic             sgn_a;
  logic             sgn_b;
  logic             in_neg_a;
  logic             in_neg_b;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic             is_div;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] spec_res;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (bus.MulDivOp)
      3'b001, 3'b100, 3'b110: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'b010: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign is_div   = bus.MulDivOp[2];
  assign in_neg_a = sgn_a & bus.Operand1[WIDTH-1];
  assign in_neg_b = sgn_b & bus.Operand2[WIDTH-1];
  assign in_mag_a = in_neg_a ? -bus.Operand1 : bus.Operand1;
  assign in_mag_b = in_neg_b ? -bus.Operand2 : bus.Operand2;
  assign div_zero = (bus.Operand2 == '0);
  assign div_ovf  = sgn_b && (bus.Operand1 == SMIN)
                 && (bus.Operand2 == '1);

  // REM/REMU have op[1] set; DIV/DIVU do not
  always_comb begin
    if (bus.MulDivOp[1])
      spec_res = div_zero ? bus.Operand1 : '0;
    else
      spec_res = div_zero ? '1 : SMIN;
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] fa;
  logic signed [2*WIDTH-1:0] fb;
  logic signed [2*WIDTH-1:0] fprod;
  logic [WIDTH-1:0]          fast_res;

  assign fa = {{WIDTH{in_neg_a}}, bus.Operand1};
  assign fb = {{WIDTH{in_neg_b}}, bus.Operand2};
  assign fprod = fa * fb;
  assign fast_res = (bus.MulDivOp[1:0] == 2'b00)
                  ? fprod[WIDTH-1:0]
                  : fprod[2*WIDTH-1:WIDTH];
`endif

  logic [WIDTH:0]     add;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     sh;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  assign add    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, mag_a} : '0);
  assign acc_nx = {add, acc[WIDTH-1:1]};
  assign sh     = {rem, quo[WIDTH-1]};
  assign diff   = sh - {1'b0, mag_b};
  assign ge     = ~diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ge};

  logic [2*WIDTH-1:0] prod_fx;
  logic [WIDTH-1:0]   quo_fx;
  logic [WIDTH-1:0]   rem_fx;
  logic [WIDTH-1:0]   fix_res;

  assign prod_fx = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_fx  = (neg_a ^ neg_b) ? -quo : quo;
  assign rem_fx  = neg_a ? -rem : rem;

  always_comb begin
    fix_res = rem_fx;
    unique case (op)
      3'b000:                 fix_res = prod_fx[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fx[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quo_fx;
      default:                fix_res = rem_fx;
    endcase
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RSTN) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (bus.Flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (bus.Start) begin
              op    <= bus.MulDivOp;
              neg_a <= in_neg_a;
              neg_b <= in_neg_b;
              mag_a <= in_mag_a;
              mag_b <= in_mag_b;
              acc   <= {{WIDTH{1'b0}}, in_mag_b};
              rem   <= '0;
              quo   <= in_mag_a;
              cnt   <= CW'(WIDTH-1);
              if (is_div && (div_zero || div_ovf)) begin
                result <= spec_res;
                done   <= 1'b1;
                state  <= DONE;
`ifdef ALU_MULDIV_FAST_MUL_EN
              end else if (!is_div) begin
                result <= fast_res;
                done   <= 1'b1;
                state  <= DONE;
`endif
              end else begin
                state <= CALC;
                busy  <= 1'b1;
              end
            end
          end
          CALC: begin
            if (op[2]) begin
              rem <= rem_nx;
              quo <= quo_nx;
            end else begin
              acc <= acc_nx;
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0)
              state <= FIXUP;
          end
          FIXUP: begin
            result <= fix_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Result = result;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv at WIDTH = 32.
// A monitor pops expected results and done cycles whenever Done pulses.
module tb_alu_muldiv;
  localparam int W = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int ML = 1;
  localparam int MB = 0;
`else
  localparam int ML = W + 2;
  localparam int MB = W + 1;
`endif
  localparam int DL = W + 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  string        name_q[$];

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W)) dut (
    .CPU_CLK  (clk),
    .CPU_RSTN (rstn),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // monitor: compare every Done pulse against the scoreboard
  always @(negedge clk) begin
    if (rstn && bus.Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got result %h expected no done",
                 bus.Result);
      end else begin
        string nm;
        logic [W-1:0] ex;
        int du;
        ex = exp_q.pop_front();
        du = due_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_result"}, bus.Result, ex);
        check({nm, "_cycle"}, W'(cyc), W'(du));
        check({nm, "_busy"}, {{(W-1){1'b0}}, bus.Busy}, '0);
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat,
                       input bit push, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (bus.Busy) begin
      checks++;
      $display("FAIL %s_idle_wait: got busy expected idle", nm);
    end
    bus.Start    = 1'b1;
    bus.MulDivOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    @(posedge clk);
    #1;
    if (push) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + lat - 1);
      name_q.push_back(nm);
    end
    if (!hold) bus.Start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
      due_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    int nb;
    bus.Start    = 1'b0;
    bus.Flush    = 1'b0;
    bus.MulDivOp = '0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.Busy}, '0);
    check("reset_done", {31'd0, bus.Done}, '0);
    check("reset_result", bus.Result, '0);
    rstn = 1'b1;

    // MUL with busy-window measurement
    issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML, 1, 0);
    nb = 0;
    @(negedge clk);
    while (bus.Busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("mul_busy_cycles", W'(nb), W'(MB));
    drain();

    issue("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, ML, 1, 0);
    issue("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, ML, 1, 0);
    issue("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,
          32'hFFFF_FFFF, ML, 1, 0);
    issue("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DL, 1, 0);
    issue("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DL, 1, 0);
    issue("divu", 3'b101, 32'd100, 32'd7, 32'd14, DL, 1, 0);
    issue("remu", 3'b111, 32'd100, 32'd7, 32'd2, DL, 1, 0);

    issue("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 0);
    check("divu_z_busy", {31'd0, bus.Busy}, '0);
    issue("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 1, 1, 0);
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 1, 1, 0);
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1, 0);
    drain();

    // flush mid-division keeps the previous result
    issue("pre_flush", 3'b101, 32'h1234, 32'd1, 32'h1234, DL, 1, 0);
    drain();
    issue("flushed", 3'b100, 32'd1000, 32'd3, '0, DL, 0, 0);
    repeat (10) @(negedge clk);
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    check("flush_busy", {31'd0, bus.Busy}, '0);
    check("flush_done", {31'd0, bus.Done}, '0);
    check("flush_result", bus.Result, 32'h1234);
    issue("post_flush", 3'b101, 32'd100, 32'd7, 32'd14, DL, 1, 0);
    drain();

    // Start together with Flush is dropped
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.Flush    = 1'b1;
    bus.MulDivOp = 3'b101;
    bus.Operand1 = 32'd9;
    bus.Operand2 = 32'd0;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    check("start_flush_busy", {31'd0, bus.Busy}, '0);
    check("start_flush_done", {31'd0, bus.Done}, '0);
    repeat (3) @(negedge clk);

    // Start held high: each op accepted in the previous DONE cycle
    issue("s_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, ML, 1, 1);
    issue("s_divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 1);
    issue("s_remu", 3'b111, 32'd100, 32'd7, 32'd2, DL, 1, 1);
    issue("s_rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 1, 1, 1);
    issue("s_mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML, 1, 0);
    drain();

    // reset during a divide
    issue("reset_div", 3'b100, 32'hFFFF_FFF9, 32'd2, '0, DL, 0, 0);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, bus.Busy}, '0);
    check("rst_mid_done", {31'd0, bus.Done}, '0);
    check("rst_mid_result", bus.Result, '0);
    rstn = 1'b1;
    issue("post_rst", 3'b110, 32'd100, 32'd7, 32'd2, DL, 1, 0);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
